// File: rtl/cam_stream_pkg.sv
// ============================================================================
//  Module      : cam_stream_pkg
//  Description : Shared types and constants for the camera pixel stream packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_stream_pkg;

  localparam int CAM_DATA_W = 12;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    DROP       = 2'd2
  } state_e;

  typedef struct packed {
    logic                  tuser;
    logic                  tlast;
    logic [CAM_DATA_W-1:0] data;
  } fifo_entry_t;

  // FIFO word = pixel data plus the tuser and tlast markers.
  function automatic int entry_width(input int data_w);
    return data_w + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// ============================================================================
//  Module      : sync_fifo_fwft
//  Description : Single-clock first-word-fall-through FIFO with full/empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_fwft #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             w_wr_en;
  logic             w_rd_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign w_rd_en = pop_i & ~empty_o;
  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_wr_en = push_i & (~full_o | w_rd_en);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/cam_pixel_stream_packer.sv
// ============================================================================
//  Module      : cam_pixel_stream_packer
//  Description : Camera RGB stream to valid/ready stream with tuser/tlast,
//                overflow drop-to-next-frame and line-length checking.
//                Define CAM_PIXEL_STREAM_STATS_EN for frame/line statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_pixel_stream_packer
  import cam_stream_pkg::*;
#(
  parameter int DATA_W            = CAM_DATA_W,
  parameter int FIFO_DEPTH        = 16,
  parameter int H_ACTIVE          = 640,
  parameter int VSYNC_ACTIVE_HIGH = 1
) (
  input  logic              i_clk_pixel,
  input  logic              i_rst,
  input  logic              i_rgb_vde,
  input  logic              i_rgb_vsync,
  input  logic [DATA_W-1:0] i_rgb_data,
  output logic [DATA_W-1:0] o_m_tdata,
  output logic              o_m_tvalid,
  input  logic              i_m_tready,
  output logic              o_m_tuser,
  output logic              o_m_tlast,
  input  logic              i_clr_err,
  output logic              o_overflow,
  output logic              o_line_err
`ifdef CAM_PIXEL_STREAM_STATS_EN
  ,
  output logic [15:0]       o_frame_cnt,
  output logic [11:0]       o_last_width,
  output logic [11:0]       o_last_height
`endif
);

  localparam int ENTRY_W = entry_width(DATA_W);
  localparam int X_W     = 16;
  localparam logic [X_W-1:0] H_ACTIVE_C = X_W'(H_ACTIVE);

  typedef struct packed {
    logic              tuser;
    logic              tlast;
    logic [DATA_W-1:0] data;
  } pix_t;

  state_e           state_q, state_d;
  pix_t             pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             sof_q, sof_d;
  logic [X_W-1:0]   x_cnt_q, x_cnt_d;
  logic             ovf_q, ovf_d;
  logic             line_err_q, line_err_d;
  logic             vsync_q;
  logic             vde_q;

  logic             w_frame_start;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_tlast_push;
  logic             w_line_chk;
  logic             w_ovf_set;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  pix_t             w_push_data;
  pix_t             w_head;
  logic [ENTRY_W-1:0] w_push_raw;
  logic [ENTRY_W-1:0] w_head_raw;

  generate
    if (VSYNC_ACTIVE_HIGH != 0) begin : g_vs_rise
      assign w_frame_start = i_rgb_vsync & ~vsync_q;
    end else begin : g_vs_fall
      assign w_frame_start = ~i_rgb_vsync & vsync_q;
    end
  endgenerate

  // Edge-detect history runs through reset so a vsync level held across reset
  // release is not mistaken for a frame start.
  always_ff @(posedge i_clk_pixel) begin
    vsync_q <= i_rgb_vsync;
    vde_q   <= i_rgb_vde;
  end

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      state_q    <= WAIT_FRAME;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      sof_q      <= 1'b0;
      x_cnt_q    <= '0;
      ovf_q      <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      sof_q      <= sof_d;
      x_cnt_q    <= x_cnt_d;
      ovf_q      <= ovf_d;
      line_err_q <= line_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    sof_d        = sof_q;
    x_cnt_d      = x_cnt_q;
    w_push_req   = 1'b0;
    w_push_data  = pend_q;
    w_tlast_push = 1'b0;

    if (w_frame_start) begin
      // Close out any line still held in pending before the new frame begins.
      if (state_q == ACTIVE && pend_vld_q) begin
        w_push_req        = 1'b1;
        w_push_data.tlast = 1'b1;
        w_tlast_push      = 1'b1;
      end
      pend_vld_d = 1'b0;
      sof_d      = 1'b1;
      x_cnt_d    = '0;
      state_d    = ACTIVE;
    end else if (state_q == ACTIVE) begin
      if (i_rgb_vde) begin
        if (pend_vld_q) begin
          w_push_req        = 1'b1;
          w_push_data.tlast = 1'b0;
        end
        pend_d.tuser = sof_q;
        pend_d.tlast = 1'b0;
        pend_d.data  = i_rgb_data;
        pend_vld_d   = 1'b1;
        sof_d        = 1'b0;
        if (x_cnt_q != '1) x_cnt_d = x_cnt_q + 1'b1;
      end else if (vde_q && pend_vld_q) begin
        w_push_req        = 1'b1;
        w_push_data.tlast = 1'b1;
        w_tlast_push      = 1'b1;
        pend_vld_d        = 1'b0;
        x_cnt_d           = '0;
      end
    end

    w_ovf_set  = w_push_req & w_fifo_full & ~w_pop;
    w_push     = w_push_req & ~w_ovf_set;
    w_line_chk = w_tlast_push & ~w_ovf_set;

    // Overflow abandons the rest of the frame; a coincident frame start still wins.
    if (w_ovf_set) begin
      pend_vld_d = 1'b0;
      x_cnt_d    = '0;
      if (!w_frame_start) state_d = DROP;
    end

    ovf_d      = (ovf_q & ~i_clr_err) | w_ovf_set;
    line_err_d = (line_err_q & ~i_clr_err) | (w_line_chk & (x_cnt_q != H_ACTIVE_C));
  end

  assign w_push_raw = w_push_data;
  assign w_head     = w_head_raw;
  assign w_pop      = ~w_fifo_empty & i_m_tready;

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk_pixel),
    .rst_i   (i_rst),
    .push_i  (w_push),
    .data_i  (w_push_raw),
    .pop_i   (w_pop),
    .data_o  (w_head_raw),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign o_m_tvalid = ~w_fifo_empty;
  assign o_m_tdata  = o_m_tvalid ? w_head.data : '0;
  assign o_m_tuser  = o_m_tvalid & w_head.tuser;
  assign o_m_tlast  = o_m_tvalid & w_head.tlast;
  assign o_overflow = ovf_q;
  assign o_line_err = line_err_q;

`ifdef CAM_PIXEL_STREAM_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [11:0] last_width_q;
  logic [11:0] y_cnt_q;
  logic [11:0] last_height_q;

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      frame_cnt_q   <= '0;
      last_width_q  <= '0;
      y_cnt_q       <= '0;
      last_height_q <= '0;
    end else begin
      if (w_line_chk) last_width_q <= x_cnt_q[11:0];
      // A line flushed by the frame start still belongs to the previous frame.
      if (w_frame_start) begin
        frame_cnt_q   <= frame_cnt_q + 16'd1;
        last_height_q <= y_cnt_q + {11'd0, w_line_chk};
        y_cnt_q       <= '0;
      end else if (w_line_chk) begin
        y_cnt_q <= y_cnt_q + 12'd1;
      end
    end
  end

  assign o_frame_cnt   = frame_cnt_q;
  assign o_last_width  = last_width_q;
  assign o_last_height = last_height_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cam_pixel_stream_packer.sv
// ============================================================================
//  Module      : tb_cam_pixel_stream_packer
//  Description : Scoreboard bench for cam_pixel_stream_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_pixel_stream_packer;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vde = 1'b0;
  logic          vsync = 1'b0;
  logic [DW-1:0] data = '0;
  logic          tready;
  logic          clr = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid, tuser, tlast, overflow, line_err;
`ifdef CAM_PIXEL_STREAM_STATS_EN
  logic [15:0]   frame_cnt;
  logic [11:0]   last_width, last_height;
`endif

  typedef struct packed {
    logic          tuser;
    logic          tlast;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp_b;
  beat_t prev_b;
  bit    prev_stall = 1'b0;
  int    checks = 0;
  int    failures = 0;
  int    rdy_mode = 1;

  cam_pixel_stream_packer #(
    .DATA_W (DW), .FIFO_DEPTH (16), .H_ACTIVE (640), .VSYNC_ACTIVE_HIGH (1)
  ) dut (
    .i_clk_pixel (clk),
    .i_rst       (rst),
    .i_rgb_vde   (vde),
    .i_rgb_vsync (vsync),
    .i_rgb_data  (data),
    .o_m_tdata   (tdata),
    .o_m_tvalid  (tvalid),
    .i_m_tready  (tready),
    .o_m_tuser   (tuser),
    .o_m_tlast   (tlast),
    .i_clr_err   (clr),
    .o_overflow  (overflow),
    .o_line_err  (line_err)
`ifdef CAM_PIXEL_STREAM_STATS_EN
    ,
    .o_frame_cnt   (frame_cnt),
    .o_last_width  (last_width),
    .o_last_height (last_height)
`endif
  );

  always #5 clk = ~clk;

  // Ready generator: 0 = stalled, 1 = always ready, 2 = random 50%.
  initial begin
    tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       tready = 1'b0;
        1:       tready = 1'b1;
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {17'd0, tvalid, tuser, tlast, tdata}, {17'd0, 1'b1, prev_b});
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", {tuser, tlast, tdata}, $time);
        end else begin
          exp_b = exp_q.pop_front();
          check("beat", {18'd0, tuser, tlast, tdata}, {18'd0, exp_b});
        end
      end
      prev_stall = tvalid && !tready;
      prev_b     = {tuser, tlast, tdata};
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    cyc(2);
    vsync = 1'b0;
    cyc(2);
  endtask

  task automatic send_line(input int n, input int base, input bit first, input bit expect_out);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      vde  = 1'b1;
      data = DW'(base + i);
      if (expect_out) begin
        b.tuser = first && (i == 0);
        b.tlast = (i == n - 1);
        b.data  = DW'(base + i);
        exp_q.push_back(b);
      end
      cyc(1);
    end
    vde  = 1'b0;
    data = '0;
    cyc(3);
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 3000) begin
      cyc(1);
      budget++;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
    cyc(4);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    beat_t b;
    cyc(3);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser_tlast", {tuser, tlast}, 0);
    check("rst_flags", {overflow, line_err}, 0);
    rst = 1'b0;
    cyc(2);

    // Full 640-pixel line, always ready.
    rdy_mode = 1;
    frame_start();
    send_line(640, 0, 1, 1);
    drain();
    check("line640_err", line_err, 0);
    check("line640_ovf", overflow, 0);

    // Short line: 639 pixels flags a length error, then clear it.
    send_line(639, 1000, 0, 1);
    drain();
    check("line639_err", line_err, 1);
    pulse_clr();
    check("line_err_clr", line_err, 0);

    // Random backpressure over two 8-pixel lines.
    frame_start();
    rdy_mode = 2;
    send_line(8, 'h200, 1, 1);
    send_line(8, 'h300, 0, 1);
    drain();
    rdy_mode = 1;
    cyc(2);
    check("rand_line_err", line_err, 1);
    pulse_clr();

    // Overflow: stalled sink, only the first 16 pixels survive.
    rdy_mode = 0;
    cyc(4);
    frame_start();
    for (int i = 0; i < 640; i++) begin
      vde  = 1'b1;
      data = DW'('h100 + i);
      if (i < 16) begin
        b.tuser = (i == 0);
        b.tlast = 1'b0;
        b.data  = DW'('h100 + i);
        exp_q.push_back(b);
      end
      cyc(1);
      if (i == 16) check("ovf_before_17th", overflow, 0);
      if (i == 17) check("ovf_after_17th", overflow, 1);
    end
    vde = 1'b0;
    cyc(3);
    send_line(20, 'h400, 0, 0);
    check("ovf_fifo_held", tvalid, 1);
    rdy_mode = 1;
    drain();
    check("ovf_no_line_err", line_err, 0);
    check("ovf_sticky", overflow, 1);
    pulse_clr();
    check("ovf_clr", overflow, 0);
    frame_start();
    send_line(8, 'h500, 1, 1);
    drain();

    // Mid-line reset with data in flight; nothing before the next vsync emerges.
    rdy_mode = 0;
    cyc(3);
    frame_start();
    for (int i = 0; i < 5; i++) begin
      vde  = 1'b1;
      data = DW'('h680 + i);
      cyc(1);
    end
    rst = 1'b1;
    cyc(1);
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_tdata", tdata, 0);
    check("mid_rst_flags", {overflow, line_err}, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data = DW'('h690 + i);
      cyc(1);
    end
    vde = 1'b0;
    rdy_mode = 1;
    cyc(5);
    send_line(8, 'h700, 0, 0);
    cyc(10);
    check("post_rst_quiet", tvalid, 0);
    frame_start();
    send_line(8, 'h600, 1, 1);
    drain();

`ifdef CAM_PIXEL_STREAM_STATS_EN
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    for (int f = 0; f < 3; f++) begin
      frame_start();
      for (int l = 0; l < 4; l++) send_line(8, 'h800 + 16 * l, (l == 0), 1);
    end
    drain();
    check("stats_frame_cnt", frame_cnt, 3);
    check("stats_last_width", last_width, 8);
    check("stats_last_height", last_height, 4);
`endif

    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
